// File: rtl/uart_cfg_cmd_if.sv
// UART-side link between the RS232 UART top and the command interpreter.
//   recirve_vld  : receive-valid, rising edge marks a new frame
//   recieve_data : received 64-bit frame, stable while recirve_vld is high
//   send_vld     : transmitter idle
//   send_en      : one-cycle pulse that starts a reply
//   send_data    : 64-bit reply frame
// master = UART top side, slave = command interpreter side.
interface uart_cfg_cmd_if;
    localparam int unsigned FRAME_W = 64;

    logic               recirve_vld;
    logic [FRAME_W-1:0] recieve_data;
    logic               send_vld;
    logic               send_en;
    logic [FRAME_W-1:0] send_data;

    modport master (
        output recirve_vld,
        output recieve_data,
        output send_vld,
        input  send_en,
        input  send_data
    );

    modport slave (
        input  recirve_vld,
        input  recieve_data,
        input  send_vld,
        output send_en,
        output send_data
    );
endinterface

// File: rtl/uart_cfg_cmd.sv
// Command interpreter behind the UART: validates 64-bit request frames,
// executes writes/reads on an 8 x 32-bit config register file (reg 7 is a
// read-only status word) and answers each accepted frame with a reply.
//   clk, rst     : system clock, asynchronous active-high reset
//   uart         : UART receive/send link (slave side)
//   cfg_regs     : registers 0-7 concatenated, reg k at [32k+31:32k]
//   cfg_wr_pulse : one-cycle pulse after a successful write
//   cfg_wr_addr  : address of the last successful write
module uart_cfg_cmd #(
    parameter logic [31:0] RST_VAL     = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    uart_cfg_cmd_if.slave uart,
    output logic [255:0]  cfg_regs,
    output logic          cfg_wr_pulse,
    output logic [2:0]    cfg_wr_addr
);
    localparam int unsigned REG_W   = 32;
    localparam int unsigned RW_REGS = 7;
    localparam int unsigned CNT_W   = 8;

    localparam logic [7:0] REQ_HDR = 8'hA5;
    localparam logic [7:0] RSP_HDR = 8'h5A;
    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_RD   = 8'h02;
    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_CSUM = 8'h01;
    localparam logic [7:0] ST_OPC  = 8'h02;
    localparam logic [7:0] ST_ADDR = 8'h03;
    localparam logic [7:0] ST_RO   = 8'h04;

    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, CHECK, EXEC, WAIT_TX, WAIT_ACK} state_t;

    state_t           state_q, state_d;
    logic             vld_q, rise_q;
    logic [63:0]      frame_q;
    logic [7:0]       status_q;
    logic [REG_W-1:0] regs_q [RW_REGS];
    logic [CNT_W-1:0] err_cnt, drop_cnt, ack_cnt;

    logic [7:0]       f_hdr, f_op, f_addr;
    logic [31:0]      f_data;
    logic             hdr_ok, wr_ok, rd_ok;
    logic [7:0]       chk_status;
    logic [31:0]      status_word, rd_data;
    logic [55:0]      reply_body;

    // XOR of the seven upper bytes of a frame
    function automatic logic [7:0] byte_xor(input logic [55:0] b);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 7; i++) x = x ^ b[8*i +: 8];
        return x;
    endfunction

    assign f_hdr       = frame_q[63:56];
    assign f_op        = frame_q[55:48];
    assign f_addr      = frame_q[47:40];
    assign f_data      = frame_q[39:8];
    assign hdr_ok      = (f_hdr == REQ_HDR);
    assign status_word = {16'h0000, drop_cnt, err_cnt};
    assign wr_ok       = (status_q == ST_OK) && (f_op == OP_WR);
    assign rd_ok       = (status_q == ST_OK) && (f_op == OP_RD);

    // Frame validation, first failing rule wins
    always_comb begin
        chk_status = ST_OK;
        if (byte_xor(frame_q[63:8]) != frame_q[7:0]) chk_status = ST_CSUM;
        else if (f_op != OP_WR && f_op != OP_RD)     chk_status = ST_OPC;
        else if (f_addr > 8'd7)                      chk_status = ST_ADDR;
        else if (f_op == OP_WR && f_addr == 8'd7)    chk_status = ST_RO;
    end

    // Read mux, address 7 selects the live status word
    always_comb begin
        rd_data = status_word;
        for (int k = 0; k < RW_REGS; k++)
            if (f_addr[2:0] == 3'(k)) rd_data = regs_q[k];
    end

    assign reply_body = {RSP_HDR, status_q, f_addr, rd_ok ? rd_data : f_data};

    always_comb begin
        cfg_regs[255:224] = status_word;
        for (int k = 0; k < RW_REGS; k++) cfg_regs[REG_W*k +: REG_W] = regs_q[k];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise_q) state_d = CHECK;
            CHECK:    state_d = hdr_ok ? EXEC : IDLE;
            EXEC:     state_d = WAIT_TX;
            WAIT_TX:  if (uart.send_vld) state_d = WAIT_ACK;
            WAIT_ACK: if (!uart.send_vld || ack_cnt == ACK_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q          <= 1'b0;
            rise_q         <= 1'b0;
            frame_q        <= '0;
            status_q       <= ST_OK;
            err_cnt        <= '0;
            drop_cnt       <= '0;
            ack_cnt        <= '0;
            uart.send_en   <= 1'b0;
            uart.send_data <= '0;
            cfg_wr_pulse   <= 1'b0;
            cfg_wr_addr    <= 3'd0;
            for (int k = 0; k < RW_REGS; k++) regs_q[k] <= RST_VAL;
        end else begin
            vld_q        <= uart.recirve_vld;
            rise_q       <= uart.recirve_vld & ~vld_q;
            uart.send_en <= 1'b0;
            cfg_wr_pulse <= 1'b0;
            ack_cnt      <= (state_q == WAIT_ACK) ? ack_cnt + CNT_W'(1) : '0;

            // Frames arriving while busy are discarded, never queued
            if (rise_q && state_q != IDLE && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + CNT_W'(1);

            case (state_q)
                IDLE: if (rise_q) frame_q <= uart.recieve_data;
                CHECK: begin
                    status_q <= chk_status;
                    if ((!hdr_ok || chk_status != ST_OK) && err_cnt != CNT_MAX)
                        err_cnt <= err_cnt + CNT_W'(1);
                end
                EXEC: begin
                    uart.send_data <= {reply_body, byte_xor(reply_body)};
                    if (wr_ok) begin
                        for (int k = 0; k < RW_REGS; k++)
                            if (f_addr[2:0] == 3'(k)) regs_q[k] <= f_data;
                        cfg_wr_pulse <= 1'b1;
                        cfg_wr_addr  <= f_addr[2:0];
                    end
                end
                WAIT_TX: if (uart.send_vld) uart.send_en <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg_cmd.sv
// Scoreboard bench for uart_cfg_cmd: stimulus pushes expected replies and
// writes, a monitor pops and compares whenever send_en / cfg_wr_pulse fire.
module tb_uart_cfg_cmd;
    localparam logic [31:0] RST_VAL     = 32'hC0FF_EE00;
    localparam int unsigned ACK_TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] cfg_regs;
    logic         cfg_wr_pulse;
    logic [2:0]   cfg_wr_addr;

    uart_cfg_cmd_if bus();

    uart_cfg_cmd #(.RST_VAL(RST_VAL), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart         (bus),
        .cfg_regs     (cfg_regs),
        .cfg_wr_pulse (cfg_wr_pulse),
        .cfg_wr_addr  (cfg_wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; bit chk_lat; int rise_cyc; } rep_t;
    typedef struct { logic [2:0] addr; logic [31:0] data; int rise_cyc; } wr_t;

    rep_t        rep_q[$];
    wr_t         wr_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          vld_force_low = 1'b0;
    bit          ack_hold_high = 1'b0;
    logic [63:0] last_rep;

    // Reference model state
    logic [31:0] m_regs [7];
    int          m_err, m_drop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_flag(input string name, input bit ok);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: condition false, required true", name);
    endtask

    function automatic logic [7:0] xsum(input logic [63:0] f);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < 8; i++) x = x ^ 8'((f >> (8 * i)) & 64'hFF);
        return x;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] hdr, input logic [7:0] op,
                                       input logic [7:0] addr, input logic [31:0] d, input bit bad);
        logic [63:0] f;
        f = {hdr, op, addr, d, 8'h00};
        f[7:0] = xsum(f) ^ (bad ? 8'h3C : 8'h00);
        return f;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0000, 8'(m_drop), 8'(m_err)};
    endfunction

    function automatic logic [255:0] m_cfg();
        logic [255:0] v;
        v[255:224] = m_status();
        for (int k = 0; k < 7; k++) v[32*k +: 32] = m_regs[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_regs[k] = RST_VAL;
        m_err  = 0;
        m_drop = 0;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic bump_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Applies one accepted frame to the model and yields the expected effects
    task automatic model_frame(input logic [63:0] f, output bit has_rep, output logic [63:0] rep,
                               output bit is_wr, output logic [2:0] wa, output logic [31:0] wd);
        logic [7:0]  op, a, st;
        logic [31:0] d, rd;
        op = f[55:48]; a = f[47:40]; d = f[39:8];
        has_rep = 1'b0; is_wr = 1'b0; wa = 3'd0; wd = 32'd0; rep = 64'd0;
        if (f[63:56] != 8'hA5) begin
            bump_err();
            return;
        end
        if (xsum(f) != f[7:0])              st = 8'h01;
        else if (op != 8'h01 && op != 8'h02) st = 8'h02;
        else if (a > 8'd7)                   st = 8'h03;
        else if (op == 8'h01 && a == 8'd7)   st = 8'h04;
        else                                 st = 8'h00;
        if (st != 8'h00) bump_err();
        rd = d;
        if (st == 8'h00 && op == 8'h02) begin
            if (a == 8'd7) rd = m_status();
            else           rd = m_regs[a[2:0]];
        end
        if (st == 8'h00 && op == 8'h01) begin
            m_regs[a[2:0]] = d;
            is_wr = 1'b1; wa = a[2:0]; wd = d;
        end
        rep = {8'h5A, st, a, rd, 8'h00};
        rep[7:0] = xsum(rep);
        has_rep = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] f, input bit accepted);
        rep_t        r;
        wr_t         w;
        bit          has_rep, is_wr;
        logic [63:0] rep;
        logic [2:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        bus.recieve_data = f;
        bus.recirve_vld  = 1'b1;
        if (accepted) begin
            model_frame(f, has_rep, rep, is_wr, wa, wd);
            if (has_rep) begin
                r.data = rep; r.chk_lat = !vld_force_low; r.rise_cyc = cyc + 1;
                rep_q.push_back(r);
                last_rep = rep;
            end
            if (is_wr) begin
                w.addr = wa; w.data = wd; w.rise_cyc = cyc + 1;
                wr_q.push_back(w);
            end
        end else begin
            bump_drop();
        end
        repeat (2) @(negedge clk);
        bus.recirve_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // UART transmitter: goes busy for a few cycles after each send_en
    initial begin
        int busy;
        busy = 0;
        bus.send_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.send_en && !ack_hold_high) busy = 3;
            else if (busy > 0) busy--;
            bus.send_vld = !vld_force_low && (busy == 0);
        end
    end

    // Monitor: compares every reply and every write pulse with the scoreboard
    initial begin
        rep_t r;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (bus.send_en) begin
                if (rep_q.size() == 0) begin
                    check_flag("unexpected_send_en", 1'b0);
                end else begin
                    r = rep_q.pop_front();
                    check("reply_data", 256'(bus.send_data), 256'(r.data));
                    if (r.chk_lat) check("send_en_latency", 256'(cyc - r.rise_cyc), 256'(4));
                end
            end
            if (cfg_wr_pulse) begin
                if (wr_q.size() == 0) begin
                    check_flag("unexpected_wr_pulse", 1'b0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 256'(cfg_wr_addr), 256'(w.addr));
                    check("wr_reg_value", 256'(cfg_regs[32*int'(w.addr) +: 32]), 256'(w.data));
                    check("wr_pulse_latency", 256'(cyc - w.rise_cyc), 256'(3));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_regs"}, cfg_regs, m_cfg());
        check({tag, "_send_data"}, 256'(bus.send_data), 256'(0));
        check({tag, "_send_en"}, 256'(bus.send_en), 256'(0));
        check({tag, "_wr_pulse"}, 256'(cfg_wr_pulse), 256'(0));
        check({tag, "_wr_addr"}, 256'(cfg_wr_addr), 256'(0));
    endtask

    initial begin
        bit stable, no_en;
        int t;
        bus.recirve_vld  = 1'b0;
        bus.recieve_data = 64'd0;
        last_rep = 64'd0;
        model_reset();
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Basic write then read-back
        send_frame(mk(8'hA5, 8'h01, 8'h02, 32'h1234_5678, 1'b0), 1'b1);
        idle(12);
        check("cfg_after_write", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h02, 8'h02, $urandom, 1'b0), 1'b1);
        idle(12);

        // One frame per error status, then the error count via reg 7
        send_frame(mk(8'hA5, 8'h01, 8'h03, $urandom, 1'b1), 1'b1); idle(12);
        check("cfg_after_bad_csum", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h07, 8'h01, $urandom, 1'b0), 1'b1); idle(12);
        check("cfg_after_bad_op", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h01, 8'h09, $urandom, 1'b0), 1'b1); idle(12);
        check("cfg_after_bad_addr", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h01, 8'h07, $urandom, 1'b0), 1'b1); idle(12);
        check("cfg_after_ro_write", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h02, 8'h07, 32'd0, 1'b0), 1'b1); idle(12);

        // Bad header: silent drop, error count only
        send_frame(mk(8'h00, 8'h01, 8'h01, $urandom, 1'b0), 1'b1); idle(12);
        check("cfg_after_bad_hdr", cfg_regs, m_cfg());

        // Randomised traffic
        for (int i = 0; i < 30; i++) begin
            logic [7:0] op, a, hdr;
            bit bad;
            if ($urandom_range(0, 9) == 0) op = 8'($urandom);
            else op = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
            a   = 8'($urandom_range(0, 9));
            bad = ($urandom_range(0, 7) == 0);
            hdr = ($urandom_range(0, 11) == 0) ? 8'h3C : 8'hA5;
            send_frame(mk(hdr, op, a, $urandom, bad), 1'b1);
            idle(12);
            check("cfg_random", cfg_regs, m_cfg());
        end

        // Transmitter busy for 100 cycles with two frames arriving meanwhile
        vld_force_low = 1'b1;
        idle(1);
        send_frame(mk(8'hA5, 8'h01, 8'h05, $urandom, 1'b0), 1'b1);
        stable = 1'b1;
        no_en  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 10 || i == 40) begin
                bus.recieve_data = mk(8'hA5, 8'h01, 8'h01, $urandom, 1'b0);
                bus.recirve_vld  = 1'b1;
                bump_drop();
            end
            if (i == 12 || i == 42) bus.recirve_vld = 1'b0;
            if (i >= 2 && bus.send_data !== last_rep) stable = 1'b0;
            if (bus.send_en) no_en = 1'b0;
        end
        check_flag("send_data_stable_while_busy", stable);
        check_flag("no_send_en_while_busy", no_en);
        vld_force_low = 1'b0;
        idle(15);
        check("cfg_after_busy", cfg_regs, m_cfg());

        // Acknowledge never arrives: timeout, then next frame accepted
        ack_hold_high = 1'b1;
        send_frame(mk(8'hA5, 8'h02, 8'h05, $urandom, 1'b0), 1'b1);
        t = 0;
        while (!bus.send_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_flag("timeout_send_en_seen", bus.send_en);
        idle(238);
        bus.recieve_data = mk(8'hA5, 8'h01, 8'h04, $urandom, 1'b0);
        bus.recirve_vld  = 1'b1;
        bump_drop();
        idle(2);
        bus.recirve_vld = 1'b0;
        ack_hold_high   = 1'b0;
        idle(25);
        send_frame(mk(8'hA5, 8'h01, 8'h06, $urandom, 1'b0), 1'b1);
        idle(12);
        check("cfg_after_timeout", cfg_regs, m_cfg());
        send_frame(mk(8'hA5, 8'h02, 8'h07, 32'd0, 1'b0), 1'b1);
        idle(12);

        // Reset while waiting to transmit: reply abandoned
        vld_force_low = 1'b1;
        idle(1);
        send_frame(mk(8'hA5, 8'h01, 8'h03, $urandom, 1'b0), 1'b1);
        void'(rep_q.pop_back());
        idle(4);
        #2 rst = 1'b1;
        #1 check("send_en_in_reset", 256'(bus.send_en), 256'(0));
        idle(2);
        model_reset();
        check_reset_outputs("midreply_reset");
        rst = 1'b0;
        vld_force_low = 1'b0;
        idle(20);
        send_frame(mk(8'hA5, 8'h02, 8'h03, $urandom, 1'b0), 1'b1); idle(12);
        send_frame(mk(8'hA5, 8'h02, 8'h07, 32'd0, 1'b0), 1'b1); idle(12);

        t = 0;
        while ((rep_q.size() != 0 || wr_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pending_replies", 256'(rep_q.size()), 256'(0));
        check("pending_writes", 256'(wr_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cfg_cmd.md
# uart_cfg_cmd

Command interpreter sitting directly downstream of the RS232 UART top: consumes each 64-bit frame delivered on the receive side (`recieve_data` / `recirve_vld`), validates it, and executes register writes and reads on an 8 x 32-bit configuration register file. It also answers every accepted frame with a 64-bit reply, driven back into the UART send side (`send_en` / `send_data` / `send_vld`). Its register outputs drive the port configuration logic.

## Interface
- `RST_VAL`, 32'h0000_0000: reset value of registers 0-6.
- `ACK_TIMEOUT`, 255: cycles to wait for `send_vld` to drop after a `send_en` pulse; valid range 1-255.
- `clk`  in  1  system clock (same clock as the UART top).
- `rst`  in  1  asynchronous, active-high reset.
- `recirve_vld`  in  1  UART receive-valid; a rising edge marks a new frame.
- `recieve_data`  in  64  received frame; stable while `recirve_vld` is high.
- `send_vld`  in  1  UART transmitter idle; `send_en` is honoured only while this is high.
- `send_en`  out  1  one-cycle pulse that starts a reply.
- `send_data`  out  64  reply frame; held from build until the next reply is built.
- `cfg_regs`  out  256  registers 0-7 concatenated; reg k is at [32k+31:32k].
- `cfg_wr_pulse`  out  1  one-cycle pulse after a successful write.
- `cfg_wr_addr`  out  3  address of the last successful write.

## Operation
- Request frame fields:
  - [63:56] header 8'hA5.
  - [55:48] opcode: 8'h01 write, 8'h02 read.
  - [47:40] address.
  - [39:8] data.
  - [7:0] checksum = XOR of bytes [63:56]..[15:8].
- Validation order, first failure wins. Status codes:
  - header ≠ A5: frame is dropped silently. No reply is sent; `err_cnt` increments.
  - checksum mismatch: status 8'h01.
  - unknown opcode: status 8'h02.
  - address > 7: status 8'h03.
  - write to address 7: status 8'h04.
  - otherwise: status 8'h00.
- Register file:
  - regs 0-6 are read/write; they reset to `RST_VAL`.
  - reg 7 is read-only status: {16'h0, drop_cnt[7:0], err_cnt[7:0]}.
  - Both counters are 8-bit, saturate at 8'hFF and reset to 0.
  - `err_cnt` increments on every frame with a nonzero status and on every silent header drop.
- Reply frame fields:
  - [63:56] 8'h5A.
  - [55:48] status.
  - [47:40] echoed address.
  - [39:8] data: read data for an OK read, echoed request data otherwise.
  - [7:0] XOR of bytes [63:56]..[15:8] of the reply.
- State machine:
  - IDLE: wait for a rising edge of `recirve_vld`, detected against a registered copy. On the edge, latch `recieve_data` and go to CHECK.
  - CHECK: compute the status. Header failure → IDLE; otherwise → EXEC.
  - EXEC: perform the write (if OK), build `send_data`, pulse `cfg_wr_pulse` for an OK write, go to WAIT_TX.
  - WAIT_TX: when `send_vld` = 1, pulse `send_en` for 1 cycle and go to WAIT_ACK.
  - WAIT_ACK: when `send_vld` = 0, go to IDLE. If `ACK_TIMEOUT` cycles elapse first, go to IDLE anyway; no error is flagged.
- A rising edge of `recirve_vld` in any state other than IDLE drops that frame and increments `drop_cnt`. It is never queued.
- An edge arriving in the same cycle as the return to IDLE is not accepted: the FSM is not yet in IDLE, so the frame counts as dropped.

## Timing
- Reset values: `send_en` = 0, `send_data` = 0, `cfg_wr_pulse` = 0, `cfg_wr_addr` = 0, `cfg_regs` = {status 0, 7 × `RST_VAL`}, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-reply clears `send_en` in the same cycle and abandons the reply; no partial state survives.
- Latency from a `recirve_vld` rising edge sampled at edge N:
  - frame latched at N+1;
  - CHECK at N+2;
  - register update, `cfg_wr_pulse`, and `send_data` valid at N+3;
  - earliest `send_en` at N+4, provided `send_vld` = 1.
- `cfg_regs` reflects a write from the cycle after EXEC onward.
- A read returns the register value current in EXEC.
- `send_data` never changes while in WAIT_TX or WAIT_ACK.

## Test plan
- After reset, write frame A5 01 02 12345678 with correct checksum, `send_vld` = 1 → `cfg_regs[95:64]` = 0x12345678, `cfg_wr_pulse` for 1 cycle with `cfg_wr_addr` = 2; reply 5A 00 02 12345678 with its checksum; `send_en` asserted exactly 4 cycles after the edge.
- Read of address 2 after the write above → reply data = 0x12345678, status 00, no `cfg_wr_pulse`.
- Each of the following → the corresponding status, registers unchanged:
  - bad checksum → 01;
  - opcode 0x07 → 02;
  - address 9 → 03;
  - write to address 7 → 04.
  After the four frames, a read of reg 7 returns `err_cnt` = 4.
- Header 0x00 → no `send_en`, `err_cnt` +1.
- Hold `send_vld` = 0 for 100 cycles during a reply, and pulse `recirve_vld` twice during that time → `send_en` is delayed until `send_vld` rises; `drop_cnt` = 2; `send_data` is stable throughout.
- After `send_en`, keep `send_vld` high → FSM returns to IDLE after 255 cycles and accepts the next frame.
- Assert `rst` during WAIT_TX → `send_en` never pulses; all registers return to reset values.
